rbm_seq_engine: RTL

Sequential, parametrised successor to the combinational RBM inference top `Main`. It computes the same two stages over packed image, weight and bias ports: a hidden layer with sigmoid activation, then a linear classifier output layer. A single time-multiplexed multiply-accumulate datapath replaces the fully parallel array, driven by a start/done handshake. It adds fixed-point scaling parameters, output saturation and an optional argmax class index.

---
 rtl/rbm_seq_engine.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/rbm_seq_engine.sv
// Time-multiplexed RBM inference: hard-sigmoid hidden layer followed by a linear classifier.
// Define RBM_SEQ_ARGMAX_EN to build the argmax class index tracker.
module rbm_seq_engine #(
   parameter int IN_W     = 12,
   parameter int FRAC     = 8,
   parameter int SIG_W    = 8,
   parameter int OUT_W    = 8,
   parameter int OUT_FRAC = 4,
   parameter int IN_DIM   = 15,
   parameter int H_DIM    = 5,
   parameter int OUT_DIM  = 2
) (
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic                                         start,
   input  logic [IN_DIM*IN_W-1:0]                       image,
   input  logic [IN_DIM*H_DIM*IN_W-1:0]                 h_weight,
   input  logic [H_DIM*IN_W-1:0]                        h_bias,
   input  logic [H_DIM*OUT_DIM*IN_W-1:0]                c_weight,
   input  logic [OUT_DIM*IN_W-1:0]                      c_bias,
   output logic                                         busy,
   output logic                                         done,
   output logic [OUT_DIM*OUT_W-1:0]                     scores,
   output logic [((OUT_DIM > 1) ? $clog2(OUT_DIM) : 1)-1:0] class_idx
);
   localparam int MAX_IH  = (IN_DIM > H_DIM) ? IN_DIM : H_DIM;
   localparam int MAX_HO  = (H_DIM > OUT_DIM) ? H_DIM : OUT_DIM;
   localparam int ACC_W   = 2*IN_W + 2 + $clog2(MAX_IH);
   localparam int IDX_W   = (MAX_IH > 1) ? $clog2(MAX_IH) : 1;
   localparam int UNIT_W  = (MAX_HO > 1) ? $clog2(MAX_HO) : 1;
   localparam int CLS_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   localparam int H_SHIFT = 2*FRAC + 2 - SIG_W;
   localparam int O_SHIFT = SIG_W + FRAC - OUT_FRAC;

   localparam logic [IDX_W-1:0]        IN_LAST  = IDX_W'(IN_DIM - 1);
   localparam logic [IDX_W-1:0]        HID_LAST = IDX_W'(H_DIM - 1);
   localparam logic [UNIT_W-1:0]       HU_LAST  = UNIT_W'(H_DIM - 1);
   localparam logic [UNIT_W-1:0]       OU_LAST  = UNIT_W'(OUT_DIM - 1);
   localparam logic signed [ACC_W-1:0] SIG_MID  = ACC_W'(2**(SIG_W-1));
   localparam logic signed [ACC_W-1:0] SIG_MAX  = ACC_W'(2**SIG_W - 1);
   localparam logic signed [ACC_W-1:0] SC_MAX   = ACC_W'(2**(OUT_W-1) - 1);
   localparam logic signed [ACC_W-1:0] SC_MIN   = ~SC_MAX;

   typedef enum logic [1:0] {S_IDLE, S_HIDDEN, S_OUTPUT} state_t;

   state_t                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [UNIT_W-1:0]       unit_q, unit_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [IN_W-1:0]  img_q [IN_DIM];
   logic signed [IN_W-1:0]  img_d [IN_DIM];
   logic [SIG_W-1:0]        h_q [H_DIM];
   logic [SIG_W-1:0]        h_d [H_DIM];
   logic signed [OUT_W-1:0] pend_q [OUT_DIM];
   logic signed [OUT_W-1:0] pend_d [OUT_DIM];
   logic [OUT_DIM*OUT_W-1:0] scores_q, scores_d;
   logic                    done_q, done_d;
`ifdef RBM_SEQ_ARGMAX_EN
   logic signed [OUT_W-1:0] best_q, best_d;
   logic [CLS_W-1:0]        best_idx_q, best_idx_d;
   logic [CLS_W-1:0]        class_q, class_d;
`endif

   logic signed [IN_W-1:0]  x_sel, hw_sel, hb_sel, cw_sel, cb_sel;
   logic [SIG_W-1:0]        h_sel;
   logic signed [ACC_W-1:0] op_a, op_b, prod, bias_term, acc_sum, act_t, sc_t;
   logic [SIG_W-1:0]        act;
   logic signed [OUT_W-1:0] sat;

   // Operand muxes decode the counters against constant slices of the live buses.
   always_comb begin
      x_sel  = '0;
      hw_sel = '0;
      hb_sel = '0;
      cw_sel = '0;
      cb_sel = '0;
      h_sel  = '0;
      for (int unsigned i = 0; i < IN_DIM; i++) begin
         if (idx_q == IDX_W'(i)) x_sel = img_q[i];
         for (int unsigned j = 0; j < H_DIM; j++)
            if (idx_q == IDX_W'(i) && unit_q == UNIT_W'(j))
               hw_sel = h_weight[(i*H_DIM + j)*IN_W +: IN_W];
      end
      for (int unsigned j = 0; j < H_DIM; j++) begin
         if (unit_q == UNIT_W'(j)) hb_sel = h_bias[j*IN_W +: IN_W];
         if (idx_q == IDX_W'(j)) h_sel = h_q[j];
         for (int unsigned k = 0; k < OUT_DIM; k++)
            if (idx_q == IDX_W'(j) && unit_q == UNIT_W'(k))
               cw_sel = c_weight[(j*OUT_DIM + k)*IN_W +: IN_W];
      end
      for (int unsigned k = 0; k < OUT_DIM; k++)
         if (unit_q == UNIT_W'(k)) cb_sel = c_bias[k*IN_W +: IN_W];

      if (state_q == S_HIDDEN) begin
         op_a      = ACC_W'(x_sel);
         op_b      = ACC_W'(hw_sel);
         bias_term = ACC_W'(hb_sel) <<< FRAC;
      end else begin
         op_a      = ACC_W'(h_sel);
         op_b      = ACC_W'(cw_sel);
         bias_term = ACC_W'(cb_sel) <<< SIG_W;
      end
      prod    = op_a * op_b;
      acc_sum = ((idx_q == '0) ? bias_term : acc_q) + prod;

      // Both fixed-point shifts fold into one arithmetic shift (floor of floor).
      act_t = (acc_sum >>> H_SHIFT) + SIG_MID;
      if (act_t[ACC_W-1])       act = '0;
      else if (act_t > SIG_MAX) act = '1;
      else                      act = act_t[SIG_W-1:0];

      sc_t = acc_sum >>> O_SHIFT;
      if (sc_t > SC_MAX)      sat = SC_MAX[OUT_W-1:0];
      else if (sc_t < SC_MIN) sat = SC_MIN[OUT_W-1:0];
      else                    sat = sc_t[OUT_W-1:0];
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      unit_d   = unit_q;
      acc_d    = acc_q;
      img_d    = img_q;
      h_d      = h_q;
      pend_d   = pend_q;
      scores_d = scores_q;
      done_d   = 1'b0;
`ifdef RBM_SEQ_ARGMAX_EN
      best_d     = best_q;
      best_idx_d = best_idx_q;
      class_d    = class_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_HIDDEN;
               idx_d   = '0;
               unit_d  = '0;
               for (int unsigned i = 0; i < IN_DIM; i++) img_d[i] = image[i*IN_W +: IN_W];
            end
         end
         S_HIDDEN: begin
            acc_d = acc_sum;
            if (idx_q == IN_LAST) begin
               for (int unsigned j = 0; j < H_DIM; j++)
                  if (unit_q == UNIT_W'(j)) h_d[j] = act;
               idx_d = '0;
               if (unit_q == HU_LAST) begin
                  unit_d  = '0;
                  state_d = S_OUTPUT;
               end else begin
                  unit_d = unit_q + 1'b1;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_OUTPUT: begin
            acc_d = acc_sum;
            if (idx_q == HID_LAST) begin
               for (int unsigned k = 0; k < OUT_DIM; k++)
                  if (unit_q == UNIT_W'(k)) pend_d[k] = sat;
`ifdef RBM_SEQ_ARGMAX_EN
               if (unit_q == '0 || sat > best_q) begin
                  best_d     = sat;
                  best_idx_d = CLS_W'(unit_q);
               end
`endif
               idx_d = '0;
               if (unit_q == OU_LAST) begin
                  state_d = S_IDLE;
                  unit_d  = '0;
                  done_d  = 1'b1;
                  for (int unsigned k = 0; k < OUT_DIM; k++)
                     scores_d[k*OUT_W +: OUT_W] = pend_d[k];
`ifdef RBM_SEQ_ARGMAX_EN
                  class_d = best_idx_d;
`endif
               end else begin
                  unit_d = unit_q + 1'b1;
               end
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         unit_q   <= '0;
         acc_q    <= '0;
         scores_q <= '0;
         done_q   <= 1'b0;
         for (int unsigned i = 0; i < IN_DIM; i++) img_q[i] <= '0;
         for (int unsigned j = 0; j < H_DIM; j++) h_q[j] <= '0;
         for (int unsigned k = 0; k < OUT_DIM; k++) pend_q[k] <= '0;
`ifdef RBM_SEQ_ARGMAX_EN
         best_q     <= '0;
         best_idx_q <= '0;
         class_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         unit_q   <= unit_d;
         acc_q    <= acc_d;
         scores_q <= scores_d;
         done_q   <= done_d;
         img_q    <= img_d;
         h_q      <= h_d;
         pend_q   <= pend_d;
`ifdef RBM_SEQ_ARGMAX_EN
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
         class_q    <= class_d;
`endif
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign scores = scores_q;
`ifdef RBM_SEQ_ARGMAX_EN
   assign class_idx = class_q;
`else
   assign class_idx = '0;
`endif

endmodule
